// File: rtl/regfile_alu_if.sv
// Control-word and display bus between the lab control FSM and the
// regfile_alu datapath stage. The FSM side is the master.
interface regfile_alu_if #(
    parameter int WIDTH = 16
);
    logic [15:0]      R_en;
    logic [3:0]       R_src;
    logic [3:0]       R_dest;
    logic             R_or_I;
    logic [7:0]       imm;
    logic [7:0]       ALU_op;
    logic             Flag_en;
    logic [3:0]       rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] result;
    logic [4:0]       flags;
    logic             illegal;

    modport master (
        output R_en, R_src, R_dest, R_or_I, imm, ALU_op, Flag_en, rd_sel,
        input  rd_data, result, flags, illegal
    );

    modport slave (
        input  R_en, R_src, R_dest, R_or_I, imm, ALU_op, Flag_en, rd_sel,
        output rd_data, result, flags, illegal
    );
endinterface

// File: rtl/regfile_alu.sv
// Datapath stage: 16 general registers, a 16-bit ALU and the {N,Z,F,L,C}
// flag register, executing one control word per clock.
module regfile_alu #(
    parameter int WIDTH = 16
) (
    input logic          clk,
    input logic          rst,
    regfile_alu_if.slave bus
);
    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_CMP,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_MOV
    } alu_op_t;

    logic [WIDTH-1:0] regs [16];
    logic [4:0]       flags_q;
    logic             illegal_q;

    alu_op_t          op;
    logic             sign_ext;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_out;
    logic [4:0]       next_flags;
    logic             write_ok;

    // Decode the op; any pattern not listed, including X/Z bits, falls to OP_NONE.
    always_comb begin
        op       = OP_NONE;
        sign_ext = 1'b0;
        case (bus.R_or_I)
            1'b0: begin
                if (bus.ALU_op[7:4] == 4'h0) begin
                    case (bus.ALU_op[3:0])
                        4'h5:    op = OP_ADD;
                        4'h9:    op = OP_SUB;
                        4'hB:    op = OP_CMP;
                        4'h1:    op = OP_AND;
                        4'h2:    op = OP_OR;
                        4'h3:    op = OP_XOR;
                        4'hD:    op = OP_MOV;
                        default: op = OP_NONE;
                    endcase
                end
            end
            1'b1: begin
                case (bus.ALU_op[7:4])
                    4'h5: begin op = OP_ADD; sign_ext = 1'b1; end
                    4'h9: begin op = OP_SUB; sign_ext = 1'b1; end
                    4'hB: begin op = OP_CMP; sign_ext = 1'b1; end
                    4'hD: begin op = OP_MOV; sign_ext = 1'b1; end
                    4'h1:    op = OP_AND;
                    4'h2:    op = OP_OR;
                    4'h3:    op = OP_XOR;
                    default: op = OP_NONE;
                endcase
            end
            default: op = OP_NONE;
        endcase
    end

    assign imm_ext  = sign_ext ? {{(WIDTH-8){bus.imm[7]}}, bus.imm}
                               : {{(WIDTH-8){1'b0}}, bus.imm};
    assign op_a     = regs[bus.R_dest];
    assign op_b     = bus.R_or_I ? imm_ext : regs[bus.R_src];
    assign sum      = {1'b0, op_a} + {1'b0, op_b};
    assign diff     = {1'b0, op_a} - {1'b0, op_b};
    assign write_ok = (op != OP_NONE) && (op != OP_CMP);

    // ALU result and the flag word that would be loaded if Flag_en is set.
    always_comb begin
        alu_out    = '0;
        next_flags = flags_q;
        case (op)
            OP_ADD: begin
                alu_out            = sum[WIDTH-1:0];
                next_flags[FLAG_C] = sum[WIDTH];
                next_flags[FLAG_F] = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                     (alu_out[WIDTH-1] != op_a[WIDTH-1]);
                next_flags[FLAG_Z] = (alu_out == '0);
                next_flags[FLAG_N] = alu_out[WIDTH-1];
            end
            OP_SUB: begin
                alu_out            = diff[WIDTH-1:0];
                next_flags[FLAG_C] = diff[WIDTH];
                next_flags[FLAG_F] = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                                     (alu_out[WIDTH-1] != op_a[WIDTH-1]);
                next_flags[FLAG_Z] = (alu_out == '0);
                next_flags[FLAG_N] = alu_out[WIDTH-1];
            end
            OP_CMP: begin
                alu_out            = diff[WIDTH-1:0];
                next_flags[FLAG_Z] = (op_a == op_b);
                next_flags[FLAG_L] = diff[WIDTH];
                next_flags[FLAG_N] = ($signed(op_a) < $signed(op_b));
            end
            OP_AND, OP_OR, OP_XOR: begin
                if (op == OP_AND)
                    alu_out = op_a & op_b;
                else if (op == OP_OR)
                    alu_out = op_a | op_b;
                else
                    alu_out = op_a ^ op_b;
                next_flags[FLAG_Z] = (alu_out == '0);
                next_flags[FLAG_N] = alu_out[WIDTH-1];
            end
            OP_MOV: begin
                alu_out = op_b;
            end
            default: begin
                alu_out = '0;
            end
        endcase
    end

    // Register file: every enabled register takes the result on a legal, non-compare op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++)
                if (write_ok && bus.R_en[i])
                    regs[i] <= alu_out;
        end
    end

    // Flag register and the sticky illegal-op indicator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (bus.Flag_en && op != OP_NONE)
                flags_q <= next_flags;
            if (op == OP_NONE && ((|bus.R_en) || bus.Flag_en))
                illegal_q <= 1'b1;
        end
    end

    assign bus.result  = alu_out;
    assign bus.rd_data = regs[bus.rd_sel];
    assign bus.flags   = flags_q;
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_regfile_alu.sv
// Self-checking bench for regfile_alu: a table of single-cycle control words
// with expected results, plus hand-written reset and read-during-write sequences.
module tb_regfile_alu;
    logic clk;
    logic rst;

    regfile_alu_if #(.WIDTH(16)) bus ();

    regfile_alu #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0]  alu_op;
        logic        r_or_i;
        logic [3:0]  r_dest;
        logic [3:0]  r_src;
        logic [7:0]  imm;
        logic [15:0] r_en;
        logic        flag_en;
        logic        chk_result;
        logic [15:0] exp_result;
        logic [3:0]  chk_idx;
        logic [15:0] exp_reg;
        logic [4:0]  exp_flags;
        logic        exp_illegal;
    } vec_t;

    typedef struct {
        logic [15:0] exp_reg;
        logic [4:0]  exp_flags;
        logic        exp_illegal;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic void add_vec(
        input logic [7:0] alu_op, input logic r_or_i, input logic [3:0] r_dest,
        input logic [3:0] r_src, input logic [7:0] imm, input logic [15:0] r_en,
        input logic flag_en, input logic chk_result, input logic [15:0] exp_result,
        input logic [3:0] chk_idx, input logic [15:0] exp_reg, input logic [4:0] exp_flags,
        input logic exp_illegal);
        vec_t v;
        v.alu_op = alu_op;     v.r_or_i = r_or_i;         v.r_dest = r_dest;
        v.r_src = r_src;       v.imm = imm;               v.r_en = r_en;
        v.flag_en = flag_en;   v.chk_result = chk_result; v.exp_result = exp_result;
        v.chk_idx = chk_idx;   v.exp_reg = exp_reg;       v.exp_flags = exp_flags;
        v.exp_illegal = exp_illegal;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic [7:0] alu_op, input logic r_or_i, input logic [3:0] r_dest,
                         input logic [3:0] r_src, input logic [7:0] imm, input logic [15:0] r_en,
                         input logic flag_en, input logic [3:0] rd_sel);
        bus.ALU_op  = alu_op;
        bus.R_or_I  = r_or_i;
        bus.R_dest  = r_dest;
        bus.R_src   = r_src;
        bus.imm     = imm;
        bus.R_en    = r_en;
        bus.Flag_en = flag_en;
        bus.rd_sel  = rd_sel;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        exp_t e;
        drive(v.alu_op, v.r_or_i, v.r_dest, v.r_src, v.imm, v.r_en, v.flag_en, v.chk_idx);
        #1;
        if (v.chk_result)
            check($sformatf("v%0d result", idx), {16'h0, bus.result}, {16'h0, v.exp_result});
        e.exp_reg     = v.exp_reg;
        e.exp_flags   = v.exp_flags;
        e.exp_illegal = v.exp_illegal;
        sb.push_back(e);
    endtask

    task automatic check_output(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            check($sformatf("v%0d scoreboard", idx), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d reg", idx), {16'h0, bus.rd_data}, {16'h0, e.exp_reg});
            check($sformatf("v%0d flags", idx), {27'h0, bus.flags}, {27'h0, e.exp_flags});
            check($sformatf("v%0d illegal", idx), {31'h0, bus.illegal}, {31'h0, e.exp_illegal});
        end
    endtask

    initial begin
        logic [15:0] fib [15];
        fib = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34,
                16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610};

        // Fibonacci run
        add_vec(8'h50, 1, 0, 0, 8'h01, 16'h0003, 1, 1, 16'h0001, 1, 16'h0001, 5'b00000, 0);
        for (int k = 2; k <= 14; k++)
            add_vec(8'h05, 0, 4'(k - 2), 4'(k - 1), 8'h00, 16'(1 << k), 1, 1, fib[k],
                    4'(k), fib[k], 5'b00000, 0);
        // Carry / zero
        add_vec(8'hD0, 1, 0, 0, 8'hFF, 16'h0001, 1, 1, 16'hFFFF, 0, 16'hFFFF, 5'b00000, 0);
        add_vec(8'h50, 1, 0, 0, 8'h01, 16'h0001, 1, 1, 16'h0000, 0, 16'h0000, 5'b01001, 0);
        // Signed overflow by repeated doubling
        add_vec(8'hD0, 1, 0, 0, 8'h40, 16'h0001, 0, 1, 16'h0040, 0, 16'h0040, 5'b01001, 0);
        for (int j = 0; j < 8; j++)
            add_vec(8'h05, 0, 0, 0, 8'h00, 16'h0001, 1, 1, 16'(16'h0080 << j), 0,
                    16'(16'h0080 << j), 5'b00000, 0);
        add_vec(8'h05, 0, 0, 0, 8'h00, 16'h0001, 1, 1, 16'h8000, 0, 16'h8000, 5'b10100, 0);
        // Compare
        add_vec(8'hD0, 1, 0, 0, 8'h05, 16'h0002, 0, 1, 16'h0005, 1, 16'h0005, 5'b10100, 0);
        add_vec(8'hD0, 1, 0, 0, 8'hFF, 16'h0004, 0, 1, 16'hFFFF, 2, 16'hFFFF, 5'b10100, 0);
        add_vec(8'h0B, 0, 1, 2, 8'h00, 16'hFFFF, 1, 1, 16'h0006, 0, 16'h8000, 5'b00110, 0);
        add_vec(8'hB0, 1, 1, 0, 8'h05, 16'h0000, 1, 1, 16'h0000, 1, 16'h0005, 5'b01100, 0);
        // Logic ops, zero-extension and Flag_en gating
        add_vec(8'h20, 1, 4, 0, 8'h80, 16'h0010, 1, 1, 16'h0085, 4, 16'h0085, 5'b00100, 0);
        add_vec(8'h10, 1, 3, 0, 8'h00, 16'h0008, 0, 1, 16'h0000, 3, 16'h0000, 5'b00100, 0);
        add_vec(8'h10, 1, 3, 0, 8'h00, 16'h0008, 1, 1, 16'h0000, 3, 16'h0000, 5'b01100, 0);
        add_vec(8'h03, 0, 4, 2, 8'h00, 16'h0020, 1, 1, 16'hFF7A, 5, 16'hFF7A, 5'b10100, 0);
        add_vec(8'h09, 0, 1, 4, 8'h00, 16'h0040, 1, 1, 16'hFF80, 6, 16'hFF80, 5'b10001, 0);
        add_vec(8'h90, 1, 1, 0, 8'hFB, 16'h0080, 1, 1, 16'h000A, 7, 16'h000A, 5'b00001, 0);
        add_vec(8'h02, 0, 3, 4, 8'h00, 16'h0100, 0, 1, 16'h0085, 8, 16'h0085, 5'b00001, 0);
        add_vec(8'h0D, 0, 0, 5, 8'h00, 16'h0200, 1, 1, 16'hFF7A, 9, 16'hFF7A, 5'b00001, 0);
        add_vec(8'h5F, 1, 7, 0, 8'h03, 16'h0400, 1, 1, 16'h000D, 10, 16'h000D, 5'b00000, 0);
        add_vec(8'h30, 1, 10, 0, 8'hF0, 16'h0800, 1, 1, 16'h00FD, 11, 16'h00FD, 5'b00000, 0);
        // Undecodable ops: harmless when idle, sticky illegal when enabled
        add_vec(8'h15, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 16'h8000, 5'b00000, 0);
        add_vec(8'h07, 0, 0, 0, 8'h01, 16'h0001, 0, 0, 16'h0000, 0, 16'h8000, 5'b00000, 1);

        // Reset state
        rst = 1'b0;
        drive(8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.rd_sel = 4'(i);
            #1;
            check($sformatf("reset R%0d", i), {16'h0, bus.rd_data}, 32'h0);
        end
        check("reset flags", {27'h0, bus.flags}, 32'h0);
        check("reset illegal", {31'h0, bus.illegal}, 32'h0);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i], i);
            @(posedge clk);
            #1;
            check_output(i);
        end

        // Asynchronous reset between edges discards the pending write
        @(negedge clk);
        drive(8'h50, 1, 0, 0, 8'h01, 16'hFFFF, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        check("async reset R0", {16'h0, bus.rd_data}, 32'h0);
        check("async reset flags", {27'h0, bus.flags}, 32'h0);
        check("async reset illegal", {31'h0, bus.illegal}, 32'h0);
        bus.rd_sel = 4'd11;
        #1;
        check("async reset R11", {16'h0, bus.rd_data}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 0);
        #1;
        check("write during reset R0", {16'h0, bus.rd_data}, 32'h0);
        check("write during reset flags", {27'h0, bus.flags}, 32'h0);

        // Read-during-write shows the old value until the edge
        @(negedge clk);
        drive(8'hD0, 1, 0, 0, 8'h12, 16'h0008, 0, 3);
        #1;
        check("rdw old R3", {16'h0, bus.rd_data}, 32'h0);
        check("rdw result", {16'h0, bus.result}, 32'h0012);
        @(posedge clk);
        #1;
        check("rdw new R3", {16'h0, bus.rd_data}, 32'h0012);
        @(negedge clk);
        drive(8'h05, 0, 3, 3, 8'h00, 16'h0000, 0, 3);
        #1;
        check("forward operand result", {16'h0, bus.result}, 32'h0024);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
